lcd_bus_responder: RTL and testbench

LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

---
 rtl/lcd_bus_responder_pkg.sv | 49 ++++
 rtl/lcd_in_sync.sv | 49 ++++
 rtl/lcd_bus_responder.sv | 182 ++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_responder_pkg.sv
// Shared definitions for the LCD bus responder (HD44780-style slave model).
// Contents: FSM state encoding, instruction opcode masks/values, timing
// defaults at 50 MHz, and the address-counter stepping helpers.
package lcd_bus_responder_pkg;

   // Timing defaults in system-clock cycles at 50 MHz.
   localparam int unsigned POR_CYCLES_DEF   = 1500000;  // 30 ms
   localparam int unsigned CMD_CYCLES_DEF   = 1850;     // 37 us
   localparam int unsigned CLEAR_CYCLES_DEF = 76500;    // 1.53 ms
   localparam int          CNT_W            = 22;

   localparam int          DDRAM_DEPTH      = 32;
   localparam logic [7:0]  BLANK_CHAR       = 8'h20;

   // FSM state encoding.
   localparam logic [1:0] ST_POR  = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_EXEC = 2'd2;

   // Instruction decode: (db & MSK_x) == VAL_x selects instruction x.
   localparam logic [7:0] OP_CLEAR  = 8'h01;
   localparam logic [7:0] MSK_HOME  = 8'hFE;
   localparam logic [7:0] VAL_HOME  = 8'h02;
   localparam logic [7:0] MSK_ENTRY = 8'hFC;
   localparam logic [7:0] VAL_ENTRY = 8'h04;
   localparam logic [7:0] MSK_DISP  = 8'hF8;
   localparam logic [7:0] VAL_DISP  = 8'h08;
   localparam logic [7:0] MSK_SHIFT = 8'hF0;
   localparam logic [7:0] VAL_SHIFT = 8'h10;
   localparam logic [7:0] MSK_FUNC  = 8'hE0;
   localparam logic [7:0] VAL_FUNC  = 8'h20;
   localparam logic [7:0] MSK_DDRAM = 8'h80;
   localparam logic [7:0] VAL_DDRAM = 8'h80;

   // DDRAM index of an address-counter value: line bit plus column.
   function automatic logic [4:0] ac_index(input logic [6:0] ac);
      return {ac[6], ac[3:0]};
   endfunction

   // Step the AC through the two 16-column lines. Stepping the 5-bit index
   // modulo 32 yields 0x0F<->0x40 and 0x4F<->0x00 wraps for free.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
      logic [4:0] idx;
      idx = ac_index(ac);
      idx = up ? idx + 5'd1 : idx - 5'd1;
      return {idx[4], 2'b00, idx[3:0]};
   endfunction

endpackage

// File: rtl/lcd_in_sync.sv
// Bus input synchronizer and EN falling-edge detector.
// Ports: clk_i/rst_i clock and async active-high reset; en_i/rs_i/rw_i/db_i
// raw bus inputs; en_o/rs_o/rw_o synchronized levels; fall_o one-cycle pulse
// after synchronized EN falls; cap_* RS/RW/DB held from the last EN-high cycle.
module lcd_in_sync (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       rs_i,
   input  logic       rw_i,
   input  logic [7:0] db_i,
   output logic       en_o,
   output logic       rs_o,
   output logic       rw_o,
   output logic       fall_o,
   output logic       cap_rs_o,
   output logic       cap_rw_o,
   output logic [7:0] cap_db_o
);

   logic [10:0] meta_q;
   logic [10:0] sync_q;
   logic        en_dly_q;
   logic [9:0]  cap_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its source, making the 2-FF chain real.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q   <= '0;
         sync_q   <= '0;
         en_dly_q <= 1'b0;
         cap_q    <= '0;
      end else begin
         meta_q   <= {en_i, rs_i, rw_i, db_i};
         sync_q   <= meta_q;
         en_dly_q <= sync_q[10];
         // Keep refreshing while EN is high; freezes on the last high cycle.
         if (sync_q[10]) cap_q <= sync_q[9:0];
      end
   end

   assign en_o   = sync_q[10];
   assign rs_o   = sync_q[9];
   assign rw_o   = sync_q[8];
   assign fall_o = en_dly_q & ~sync_q[10];
   assign {cap_rs_o, cap_rw_o, cap_db_o} = cap_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// LCD bus responder: models the bus side of an HD44780-style character LCD.
// Ports: Clock/Reset; LCD_EN/LCD_RS/LCD_RW/LCD_DADOS_IN controller bus;
// LCD_DADOS_OUT/LCD_DADOS_OE read-back path; Busy flag; Display_On, Two_Line,
// Inc_Dir current mode bits; Err one-cycle reject pulse; Dbg_Addr/Dbg_Data
// combinational DDRAM peek port.
module lcd_bus_responder
   import lcd_bus_responder_pkg::*;
#(
   parameter int unsigned POR_CYCLES   = POR_CYCLES_DEF,
   parameter int unsigned CMD_CYCLES   = CMD_CYCLES_DEF,
   parameter int unsigned CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       LCD_EN,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic [7:0] LCD_DADOS_IN,
   output logic [7:0] LCD_DADOS_OUT,
   output logic       LCD_DADOS_OE,
   output logic       Busy,
   output logic       Display_On,
   output logic       Two_Line,
   output logic       Inc_Dir,
   output logic       Err,
   input  logic [4:0] Dbg_Addr,
   output logic [7:0] Dbg_Data
);

   localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

   logic             en_s, rs_s, rw_s, fall;
   logic             cap_rs, cap_rw;
   logic [7:0]       cap_db;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       ac_q, ac_d;
   logic             disp_q, disp_d;
   logic             two_q, two_d;
   logic             inc_q, inc_d;
   logic             err_q, err_d;
   logic             mem_we, mem_clr;
   logic [7:0]       mem_q [0:DDRAM_DEPTH-1];
   logic             oe_q;
   logic [7:0]       out_q;
   logic             busy;

   lcd_in_sync u_sync (
      .clk_i    (Clock),
      .rst_i    (Reset),
      .en_i     (LCD_EN),
      .rs_i     (LCD_RS),
      .rw_i     (LCD_RW),
      .db_i     (LCD_DADOS_IN),
      .en_o     (en_s),
      .rs_o     (rs_s),
      .rw_o     (rw_s),
      .fall_o   (fall),
      .cap_rs_o (cap_rs),
      .cap_rw_o (cap_rw),
      .cap_db_o (cap_db)
   );

   assign busy = (state_q != ST_IDLE);

   // NOTE: every variable gets a default at the top of the block, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ac_d    = ac_q;
      disp_d  = disp_q;
      two_d   = two_q;
      inc_d   = inc_q;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      mem_clr = 1'b0;

      case (state_q)
         ST_POR: begin
            if (cnt_q == POR_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_EXEC: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_IDLE: ;
         default: state_d = ST_POR;
      endcase

      if (fall) begin
         if (cap_rw && !cap_rs) begin
            // Status read: served on the read path only, never rejected.
         end else if (busy) begin
            err_d = 1'b1;
         end else begin
            state_d = ST_EXEC;
            cnt_d   = CMD_LOAD;
            if (cap_rs) begin
               mem_we = !cap_rw;
               ac_d   = ac_step(ac_q, inc_q);
            end else if (cap_db == OP_CLEAR) begin
               mem_clr = 1'b1;
               ac_d    = '0;
               inc_d   = 1'b1;
               cnt_d   = CLEAR_LOAD;
            end else if ((cap_db & MSK_HOME) == VAL_HOME) begin
               ac_d  = '0;
               cnt_d = CLEAR_LOAD;
            end else if ((cap_db & MSK_ENTRY) == VAL_ENTRY) begin
               inc_d = cap_db[1];
            end else if ((cap_db & MSK_DISP) == VAL_DISP) begin
               disp_d = cap_db[2];
            end else if ((cap_db & MSK_SHIFT) == VAL_SHIFT) begin
               if (!cap_db[3]) ac_d = ac_step(ac_q, cap_db[2]);
            end else if ((cap_db & MSK_FUNC) == VAL_FUNC) begin
               two_d = cap_db[3];
               err_d = !cap_db[4];  // 4-bit interface is not modelled
            end else if ((cap_db & MSK_DDRAM) == VAL_DDRAM) begin
               // Legal DDRAM addresses are 0x00-0x0F and 0x40-0x4F.
               if (cap_db[5:4] == 2'b00) ac_d  = cap_db[6:0];
               else                      err_d = 1'b1;
            end
            // 0x00 and CGRAM-address instructions fall through as no-ops.
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_POR;
         cnt_q   <= '0;
         ac_q    <= '0;
         disp_q  <= 1'b0;
         two_q   <= 1'b0;
         inc_q   <= 1'b1;
         err_q   <= 1'b0;
         oe_q    <= 1'b0;
         out_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ac_q    <= ac_d;
         disp_q  <= disp_d;
         two_q   <= two_d;
         inc_q   <= inc_d;
         err_q   <= err_d;
         oe_q    <= en_s & rw_s;
         if (en_s && rw_s) out_q <= rs_s ? mem_q[ac_index(ac_q)] : {busy, ac_q};
      end
   end

   // NOTE: DDRAM is a reset flop array rather than a RAM macro, because both
   // reset and the clear instruction must blank all 32 cells in one cycle.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DDRAM_DEPTH; i++) mem_q[i] <= BLANK_CHAR;
      end else if (mem_clr) begin
         for (int i = 0; i < DDRAM_DEPTH; i++) mem_q[i] <= BLANK_CHAR;
      end else if (mem_we) begin
         mem_q[ac_index(ac_q)] <= cap_db;
      end
   end

   assign LCD_DADOS_OUT = out_q;
   assign LCD_DADOS_OE  = oe_q;
   assign Busy          = busy;
   assign Display_On    = disp_q;
   assign Two_Line      = two_q;
   assign Inc_Dir       = inc_q;
   assign Err           = err_q;
   assign Dbg_Data      = mem_q[Dbg_Addr];

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder with short timing parameters.
module tb_lcd_bus_responder;

   localparam int POR_C = 10;
   localparam int CMD_C = 8;
   localparam int CLR_C = 20;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       LCD_EN, LCD_RS, LCD_RW;
   logic [7:0] LCD_DADOS_IN;
   logic [7:0] LCD_DADOS_OUT;
   logic       LCD_DADOS_OE;
   logic       Busy, Display_On, Two_Line, Inc_Dir, Err;
   logic [4:0] Dbg_Addr;
   logic [7:0] Dbg_Data;

   always #5 Clock = ~Clock;

   lcd_bus_responder #(
      .POR_CYCLES   (POR_C),
      .CMD_CYCLES   (CMD_C),
      .CLEAR_CYCLES (CLR_C)
   ) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .LCD_EN        (LCD_EN),
      .LCD_RS        (LCD_RS),
      .LCD_RW        (LCD_RW),
      .LCD_DADOS_IN  (LCD_DADOS_IN),
      .LCD_DADOS_OUT (LCD_DADOS_OUT),
      .LCD_DADOS_OE  (LCD_DADOS_OE),
      .Busy          (Busy),
      .Display_On    (Display_On),
      .Two_Line      (Two_Line),
      .Inc_Dir       (Inc_Dir),
      .Err           (Err),
      .Dbg_Addr      (Dbg_Addr),
      .Dbg_Data      (Dbg_Data)
   );

   typedef struct {
      logic       rs;
      logic       rw;
      logic [7:0] db;
      int         exp_err;
      int         exp_busy;
      logic       exp_two;
      logic       exp_disp;
      logic       exp_inc;
      logic [6:0] exp_ac;
      logic [4:0] dbg_a;
      logic [7:0] dbg_d;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t       vq[$];
   logic [7:0] exp_q[$];   // scoreboard of expected read-back bytes
   int         n_checks = 0;
   int         n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic av(input logic rs, input logic rw, input logic [7:0] db,
                     input int err, input int busy, input logic two,
                     input logic disp, input logic inc, input logic [6:0] ac,
                     input logic [4:0] da, input logic [7:0] dd, input logic [7:0] rd);
      vec_t v;
      v = '{rs, rw, db, err, busy, two, disp, inc, ac, da, dd, rd};
      vq.push_back(v);
   endtask

   // One bus transfer: EN high for 3 cycles, then count Err/Busy samples
   // over a window of `win` cycles after EN falls.
   task automatic strobe(input logic rs, input logic rw, input logic [7:0] db,
                         input int win, output int errs, output int busys);
      errs  = 0;
      busys = 0;
      @(negedge Clock);
      LCD_RS = rs; LCD_RW = rw; LCD_DADOS_IN = db; LCD_EN = 1'b1;
      repeat (3) @(negedge Clock);
      LCD_EN = 1'b0;
      for (int i = 0; i < win; i++) begin
         @(negedge Clock);
         if (Err)  errs++;
         if (Busy) busys++;
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (Busy && n < 100) begin
         @(negedge Clock);
         n++;
      end
      check(name, Busy, 0);
   endtask

   task automatic status_read(input logic [6:0] ac);
      int e, b;
      exp_q.push_back({1'b0, ac});
      strobe(1'b0, 1'b1, 8'h00, 6, e, b);
   endtask

   task automatic check_blank(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         Dbg_Addr = 5'(i);
         #1;
         if (Dbg_Data !== 8'h20) bad++;
      end
      check(name, bad, 0);
   endtask

   // Read-path monitor: pops the scoreboard on every OE rising edge.
   initial begin
      logic       prev;
      logic [7:0] e;
      prev = 1'b0;
      forever begin
         @(negedge Clock);
         if (LCD_DADOS_OE && !prev) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL rd_unexpected: got 0x%0h, required no read", LCD_DADOS_OUT);
            end else begin
               e = exp_q.pop_front();
               check("rd_data", LCD_DADOS_OUT, e);
            end
         end
         prev = LCD_DADOS_OE;
      end
   end

   initial begin
      int e, b;
      Reset = 1'b1; LCD_EN = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
      LCD_DADOS_IN = 8'h00; Dbg_Addr = 5'd0;

      //             rs rw  db   err busy two disp inc  ac     dbg  data  rd
      av(0, 0, 8'h38, 0, CMD_C, 1, 0, 1, 7'h00,  0, 8'h20, 8'h00);
      av(0, 0, 8'h0C, 0, CMD_C, 1, 1, 1, 7'h00,  0, 8'h20, 8'h00);
      av(0, 0, 8'h06, 0, CMD_C, 1, 1, 1, 7'h00,  0, 8'h20, 8'h00);
      av(0, 0, 8'h01, 0, CLR_C, 1, 1, 1, 7'h00,  0, 8'h20, 8'h00);
      av(1, 0, 8'h41, 0, CMD_C, 1, 1, 1, 7'h01,  0, 8'h41, 8'h00);
      av(0, 0, 8'h8F, 0, CMD_C, 1, 1, 1, 7'h0F,  0, 8'h41, 8'h00);
      av(1, 0, 8'h42, 0, CMD_C, 1, 1, 1, 7'h40, 15, 8'h42, 8'h00);
      av(1, 0, 8'h43, 0, CMD_C, 1, 1, 1, 7'h41, 16, 8'h43, 8'h00);
      av(0, 0, 8'h04, 0, CMD_C, 1, 1, 0, 7'h41, 15, 8'h42, 8'h00);
      av(0, 0, 8'h80, 0, CMD_C, 1, 1, 0, 7'h00, 16, 8'h43, 8'h00);
      av(1, 0, 8'h44, 0, CMD_C, 1, 1, 0, 7'h4F,  0, 8'h44, 8'h00);
      av(0, 0, 8'hD0, 1, CMD_C, 1, 1, 0, 7'h4F,  0, 8'h44, 8'h00);
      av(0, 0, 8'h14, 0, CMD_C, 1, 1, 0, 7'h00, 15, 8'h42, 8'h00);
      av(0, 0, 8'h10, 0, CMD_C, 1, 1, 0, 7'h4F, 16, 8'h43, 8'h00);
      av(0, 0, 8'h1C, 0, CMD_C, 1, 1, 0, 7'h4F, 31, 8'h20, 8'h00);
      av(0, 0, 8'h20, 1, CMD_C, 0, 1, 0, 7'h4F,  0, 8'h44, 8'h00);
      av(1, 1, 8'h00, 0, CMD_C, 0, 1, 0, 7'h4E, 31, 8'h20, 8'h20);
      av(0, 0, 8'h02, 0, CLR_C, 0, 1, 0, 7'h00, 16, 8'h43, 8'h00);
      av(0, 0, 8'h40, 0, CMD_C, 0, 1, 0, 7'h00, 15, 8'h42, 8'h00);
      av(0, 0, 8'h08, 0, CMD_C, 0, 0, 0, 7'h00,  0, 8'h44, 8'h00);
      av(0, 1, 8'h00, 0, 0,     0, 0, 0, 7'h00,  0, 8'h44, 8'h00);
      av(0, 0, 8'h01, 0, CLR_C, 0, 0, 1, 7'h00, 16, 8'h20, 8'h00);

      // Reset state.
      repeat (3) @(negedge Clock);
      check("rst_busy", Busy, 1);
      check("rst_oe", LCD_DADOS_OE, 0);
      check("rst_out", LCD_DADOS_OUT, 8'h00);
      check("rst_err", Err, 0);
      check("rst_modes", {Two_Line, Display_On, Inc_Dir}, 3'b001);
      check_blank("rst_ddram");

      // Write during power-on busy: rejected, then POR ends on time.
      Reset = 1'b0;
      repeat (2) @(negedge Clock);
      LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_DADOS_IN = 8'h38; LCD_EN = 1'b1;
      @(negedge Clock);
      LCD_EN = 1'b0;
      e = 0;
      repeat (6) begin
         @(negedge Clock);
         if (Err) e++;
      end
      check("por_err", e, 1);
      check("por_two_line", Two_Line, 0);
      check("por_busy_9", Busy, 1);
      @(negedge Clock);
      check("por_busy_10", Busy, 0);

      // Table-driven transfers, each followed by a status read of AC.
      foreach (vq[i]) begin
         if (vq[i].rw) exp_q.push_back(vq[i].exp_rd);
         strobe(vq[i].rs, vq[i].rw, vq[i].db, 40, e, b);
         check($sformatf("v%0d_err", i), e, vq[i].exp_err);
         check($sformatf("v%0d_busy", i), b, vq[i].exp_busy);
         check($sformatf("v%0d_modes", i), {Two_Line, Display_On, Inc_Dir},
               {vq[i].exp_two, vq[i].exp_disp, vq[i].exp_inc});
         Dbg_Addr = vq[i].dbg_a;
         #1;
         check($sformatf("v%0d_ddram", i), Dbg_Data, vq[i].dbg_d);
         wait_idle($sformatf("v%0d_idle", i));
         status_read(vq[i].exp_ac);
      end

      // Status read and data write while executing a clear.
      strobe(1'b0, 1'b0, 8'h01, 4, e, b);
      check("exec_clear_err", e, 0);
      exp_q.push_back(8'h80);
      strobe(1'b0, 1'b1, 8'h00, 4, e, b);
      check("exec_status_err", e, 0);
      strobe(1'b1, 1'b0, 8'h55, 4, e, b);
      check("exec_write_err", e, 1);
      wait_idle("exec_idle");
      Dbg_Addr = 5'd0;
      #1;
      check("exec_ddram", Dbg_Data, 8'h20);
      status_read(7'h00);

      // Reset in the middle of a data write strobe.
      strobe(1'b1, 1'b0, 8'h5A, 40, e, b);
      Dbg_Addr = 5'd0;
      #1;
      check("pre_rst_ddram", Dbg_Data, 8'h5A);
      @(negedge Clock);
      LCD_RS = 1'b1; LCD_RW = 1'b0; LCD_DADOS_IN = 8'h77; LCD_EN = 1'b1;
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      check("mid_rst_busy", Busy, 1);
      check("mid_rst_oe", LCD_DADOS_OE, 0);
      LCD_EN = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      e = 0;
      repeat (8) begin
         @(negedge Clock);
         if (Err || LCD_DADOS_OE) e++;
      end
      check("post_rst_quiet", e, 0);
      check("post_rst_busy", Busy, 1);
      check_blank("post_rst_ddram");

      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
